// File: rtl/control_unit.sv
// Main instruction decoder: {OP, VEC} -> registered datapath control word, 1-cycle latency.
// Define VECTOR_OPS_EN to enable the vector ALU variants and the vector shift opcodes.
module control_unit (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] OP,
  input  logic       VEC,
  output logic       REG_WRITE,
  output logic       MEM_TO_REG,
  output logic       MEM_WRITE,
  output logic [3:0] ALU_CONTROL,
  output logic [1:0] ALU_SRC,
  output logic       BRANCH,
  output logic       NOT_EQUAL
);

  localparam logic [5:0] OpAdd  = 6'b000000;
  localparam logic [5:0] OpAddi = 6'b000001;
  localparam logic [5:0] OpSub  = 6'b000010;
  localparam logic [5:0] OpSubi = 6'b000011;
  localparam logic [5:0] OpXor  = 6'b000100;
  localparam logic [5:0] OpXori = 6'b000101;
  localparam logic [5:0] OpMult = 6'b000110;
  localparam logic [5:0] OpSlv  = 6'b000111;
  localparam logic [5:0] OpSrv  = 6'b001000;
  localparam logic [5:0] OpSclv = 6'b001001;
  localparam logic [5:0] OpScrv = 6'b001010;
  localparam logic [5:0] OpLw   = 6'b001011;
  localparam logic [5:0] OpSw   = 6'b001100;
  localparam logic [5:0] OpJ    = 6'b001101;
  localparam logic [5:0] OpBeq  = 6'b010000;

  localparam logic [1:0] SrcReg   = 2'b00;
  localparam logic [1:0] SrcImm   = 2'b01;
  localparam logic [1:0] SrcVec   = 2'b10;
  localparam logic [1:0] SrcShamt = 2'b11;

  logic       w_reg_write;
  logic       w_mem_to_reg;
  logic       w_mem_write;
  logic [3:0] w_alu_control;
  logic [1:0] w_alu_src;
  logic       w_branch;
  logic       w_not_equal;
  logic       w_vec;

`ifdef VECTOR_OPS_EN
  assign w_vec = VEC;
`else
  logic w_unused_vec;
  assign w_unused_vec = VEC;
  assign w_vec        = 1'b0;
`endif

  always_comb begin
    w_reg_write   = 1'b0;
    w_mem_to_reg  = 1'b0;
    w_mem_write   = 1'b0;
    w_alu_control = 4'b0000;
    w_alu_src     = SrcReg;
    w_branch      = 1'b0;
    w_not_equal   = 1'b0;
    // Vector variants set ALU_CONTROL[3] and take operand B from the vector file.
    unique case (OP)
      OpAdd, OpSub, OpXor: begin
        w_reg_write   = 1'b1;
        w_alu_control = {w_vec, 1'b0, OP[2:1]};
        w_alu_src     = w_vec ? SrcVec : SrcReg;
      end
      OpAddi, OpSubi, OpXori: begin
        w_reg_write   = 1'b1;
        w_alu_control = {2'b00, OP[2:1]};
        w_alu_src     = SrcImm;
      end
      OpMult: begin
        w_reg_write   = 1'b1;
        w_alu_control = 4'b0011;
      end
`ifdef VECTOR_OPS_EN
      OpSlv:  begin w_reg_write = 1'b1; w_alu_control = 4'b0100; w_alu_src = SrcShamt; end
      OpSrv:  begin w_reg_write = 1'b1; w_alu_control = 4'b0101; w_alu_src = SrcShamt; end
      OpSclv: begin w_reg_write = 1'b1; w_alu_control = 4'b0110; w_alu_src = SrcShamt; end
      OpScrv: begin w_reg_write = 1'b1; w_alu_control = 4'b0111; w_alu_src = SrcShamt; end
`endif
      OpLw: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_alu_src    = SrcImm;
      end
      OpSw: begin
        w_mem_write = 1'b1;
        w_alu_src   = SrcImm;
      end
      // ALU op 1111 never yields zero, so BRANCH with NOT_EQUAL makes the jump unconditional.
      OpJ: begin
        w_alu_control = 4'b1111;
        w_branch      = 1'b1;
        w_not_equal   = 1'b1;
      end
      OpBeq: begin
        w_alu_control = 4'b0001;
        w_branch      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      REG_WRITE   <= 1'b0;
      MEM_TO_REG  <= 1'b0;
      MEM_WRITE   <= 1'b0;
      ALU_CONTROL <= 4'b0000;
      ALU_SRC     <= SrcReg;
      BRANCH      <= 1'b0;
      NOT_EQUAL   <= 1'b0;
    end else begin
      REG_WRITE   <= w_reg_write;
      MEM_TO_REG  <= w_mem_to_reg;
      MEM_WRITE   <= w_mem_write;
      ALU_CONTROL <= w_alu_control;
      ALU_SRC     <= w_alu_src;
      BRANCH      <= w_branch;
      NOT_EQUAL   <= w_not_equal;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Table-driven, scoreboarded bench for control_unit; expectations follow VECTOR_OPS_EN.
module tb_control_unit;

  logic       CLK = 1'b0;
  logic       RST;
  logic [5:0] OP;
  logic       VEC;
  logic       REG_WRITE, MEM_TO_REG, MEM_WRITE, BRANCH, NOT_EQUAL;
  logic [3:0] ALU_CONTROL;
  logic [1:0] ALU_SRC;

  control_unit dut (
    .CLK        (CLK),
    .RST        (RST),
    .OP         (OP),
    .VEC        (VEC),
    .REG_WRITE  (REG_WRITE),
    .MEM_TO_REG (MEM_TO_REG),
    .MEM_WRITE  (MEM_WRITE),
    .ALU_CONTROL(ALU_CONTROL),
    .ALU_SRC    (ALU_SRC),
    .BRANCH     (BRANCH),
    .NOT_EQUAL  (NOT_EQUAL)
  );

  always #5 CLK = ~CLK;

  // Control word packing: {REG_WRITE, MEM_TO_REG, MEM_WRITE, ALU_CONTROL, ALU_SRC, BRANCH, NOT_EQUAL}
  logic [10:0] w_out;
  assign w_out = {REG_WRITE, MEM_TO_REG, MEM_WRITE, ALU_CONTROL, ALU_SRC, BRANCH, NOT_EQUAL};

  typedef struct {
    string       name;
    logic        rst;
    logic [5:0]  op;
    logic        vec;
    logic [10:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [10:0] exp;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [10:0] cw(input logic rw, input logic mr, input logic mw,
                                     input logic [3:0] alu, input logic [1:0] src,
                                     input logic br, input logic ne);
    return {rw, mr, mw, alu, src, br, ne};
  endfunction

  function automatic vec_t mk(input string name, input logic rst, input logic [5:0] op,
                              input logic vec, input logic [10:0] exp);
    vec_t v;
    v.name = name; v.rst = rst; v.op = op; v.vec = vec; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [10:0] exp);
    n_cmp++;
    if (w_out !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", name, w_out, exp);
    end
  endtask

  // Drive one instruction, push its expectation, then pop and compare after the edge.
  task automatic step(input vec_t v);
    sb_t e;
    RST = v.rst; OP = v.op; VEC = v.vec;
    sb_q.push_back('{v.name, v.exp});
    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    check(e.name, e.exp);
  endtask

  logic [10:0] zero;
  logic [10:0] add_w, sub_w, xor_w, j_w, lw_w;

  initial begin
    zero  = '0;
    add_w = cw(1, 0, 0, 4'b0000, 2'b00, 0, 0);
    sub_w = cw(1, 0, 0, 4'b0001, 2'b00, 0, 0);
    xor_w = cw(1, 0, 0, 4'b0010, 2'b00, 0, 0);
    j_w   = cw(0, 0, 0, 4'b1111, 2'b00, 1, 1);
    lw_w  = cw(1, 1, 0, 4'b0000, 2'b01, 0, 0);

    tbl.push_back(mk("reset",     1, 6'b000000, 0, zero));
    tbl.push_back(mk("add",       0, 6'b000000, 0, add_w));
    tbl.push_back(mk("addi",      0, 6'b000001, 0, cw(1, 0, 0, 4'b0000, 2'b01, 0, 0)));
`ifdef VECTOR_OPS_EN
    tbl.push_back(mk("addv",      0, 6'b000000, 1, cw(1, 0, 0, 4'b1000, 2'b10, 0, 0)));
    tbl.push_back(mk("subv",      0, 6'b000010, 1, cw(1, 0, 0, 4'b1001, 2'b10, 0, 0)));
    tbl.push_back(mk("xorv",      0, 6'b000100, 1, cw(1, 0, 0, 4'b1010, 2'b10, 0, 0)));
    tbl.push_back(mk("slv",       0, 6'b000111, 0, cw(1, 0, 0, 4'b0100, 2'b11, 0, 0)));
    tbl.push_back(mk("srv",       0, 6'b001000, 1, cw(1, 0, 0, 4'b0101, 2'b11, 0, 0)));
    tbl.push_back(mk("sclv",      0, 6'b001001, 0, cw(1, 0, 0, 4'b0110, 2'b11, 0, 0)));
    tbl.push_back(mk("scrv",      0, 6'b001010, 0, cw(1, 0, 0, 4'b0111, 2'b11, 0, 0)));
`else
    tbl.push_back(mk("addv_off",  0, 6'b000000, 1, add_w));
    tbl.push_back(mk("subv_off",  0, 6'b000010, 1, sub_w));
    tbl.push_back(mk("xorv_off",  0, 6'b000100, 1, xor_w));
    tbl.push_back(mk("slv_off",   0, 6'b000111, 0, zero));
    tbl.push_back(mk("srv_off",   0, 6'b001000, 1, zero));
    tbl.push_back(mk("sclv_off",  0, 6'b001001, 0, zero));
    tbl.push_back(mk("scrv_off",  0, 6'b001010, 0, zero));
`endif
    tbl.push_back(mk("sub",       0, 6'b000010, 0, sub_w));
    tbl.push_back(mk("subi",      0, 6'b000011, 0, cw(1, 0, 0, 4'b0001, 2'b01, 0, 0)));
    tbl.push_back(mk("xor",       0, 6'b000100, 0, xor_w));
    tbl.push_back(mk("xori",      0, 6'b000101, 0, cw(1, 0, 0, 4'b0010, 2'b01, 0, 0)));
    tbl.push_back(mk("mult",      0, 6'b000110, 0, cw(1, 0, 0, 4'b0011, 2'b00, 0, 0)));
    tbl.push_back(mk("mult_vec",  0, 6'b000110, 1, cw(1, 0, 0, 4'b0011, 2'b00, 0, 0)));
    tbl.push_back(mk("addi_vec",  0, 6'b000001, 1, cw(1, 0, 0, 4'b0000, 2'b01, 0, 0)));
    tbl.push_back(mk("lw",        0, 6'b001011, 0, lw_w));
    tbl.push_back(mk("sw",        0, 6'b001100, 0, cw(0, 0, 1, 4'b0000, 2'b01, 0, 0)));
    tbl.push_back(mk("j",         0, 6'b001101, 0, j_w));
    tbl.push_back(mk("beq",       0, 6'b010000, 1, cw(0, 0, 0, 4'b0001, 2'b00, 1, 0)));
    tbl.push_back(mk("nop",       0, 6'b111111, 0, zero));
    tbl.push_back(mk("op_011111", 0, 6'b011111, 1, zero));
    tbl.push_back(mk("op_001110", 0, 6'b001110, 0, zero));
    tbl.push_back(mk("op_100000", 0, 6'b100000, 0, zero));

    RST = 1'b1; OP = 6'b000000; VEC = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Outputs hold for the whole cycle after the sampling edge.
    step(mk("j_again", 0, 6'b001101, 0, j_w));
    OP = 6'b001011;
    #4;
    check("j_hold_midcycle", j_w);

    // Reset mid-stream discards the sampled instruction; next edge decodes normally.
    step(mk("lw_pre_rst", 0, 6'b001011, 0, lw_w));
    step(mk("rst_over_j", 1, 6'b001101, 1, zero));
    step(mk("rst_over_lw", 1, 6'b001011, 0, zero));
    step(mk("post_rst_add", 0, 6'b000000, 0, add_w));
    step(mk("post_rst_j", 0, 6'b001101, 0, j_w));

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left, want 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
